buzzer_driver: RTL
==================

// Module: buzzer_driver
// PURPOSE
//  Tone generator at the output end of the note bus. The mode controller drives note/octave codes.
//  This block turns them into a 50%-duty square wave on the piezo speaker pin.
//  A new note takes effect only at a half-period boundary, so the output never glitches.
//  A silent gap separates consecutive different notes so repeated melody notes stay audible.
// PARAMETERS
//  GAP_CYCLES  1_000_000  silent clk cycles inserted between two different sounding notes (10 ms @100 MHz)
//  CNT_W       19         half-period counter width; must hold 382220
// PORTS
//  clk            input   1  system clock, 100 MHz
//  reset          input   1  synchronous, active-low reset
//  enable         input   1  1 = sound allowed; 0 = force silence
//  note_in        input   4  0 = rest; 1..7 = do..si; 8..15 = rest
//  octave_in      input   2  00 = low; 01 = middle; 10 = high; 11 = rest
//  speaker        output  1  square-wave drive to buzzer
//  playing        output  1  1 while FSM is in PLAY
//  note_active    output  4  note currently sounding (0 when not in PLAY)
//  octave_active  output  2  octave currently sounding (00 when not in PLAY)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; speaker=0; playing=0; note_active=0; octave_active=0; counters=0.
//  Reset overrides everything, including mid-period and mid-gap.
//  Input capture: enable, note_in and octave_in are registered every clk (1-cycle capture stage).
//  Target half-period H (combinational from the registered inputs), middle octave:
//   1:191110  2:170266  3:151685  4:143172  5:127551  6:113636  7:101240
//   octave 00: H<<1.  octave 10: H>>1 (truncating).  rest/invalid code: no target (tgt_valid=0).
//  FSM states:
//   IDLE:
//    - speaker=0.
//    - When enable_r && tgt_valid: latch cur_H, note_active and octave_active; cnt=0; speaker=1; go to PLAY.
//    - Latency: port change at edge k, then PLAY with speaker=1 after edge k+2.
//   PLAY:
//    - cnt increments each clk.
//    - When cnt==cur_H-1: cnt=0 and speaker toggles. The speaker holds each level exactly cur_H cycles.
//    - enable_r==0: go to IDLE immediately; speaker=0 on the same edge.
//    - At a toggle edge with a target different from the latched one: speaker=0, gcnt=0, go to GAP.
//    - At a toggle edge with no target (rest): speaker=0, go to GAP.
//    - An identical target keeps PLAY with no gap and no phase reset.
//    - Target changes between boundaries are ignored until the next boundary; the latest value wins.
//   GAP:
//    - speaker=0; playing=0; note_active=0; gcnt increments.
//    - When gcnt==GAP_CYCLES-1: if enable_r && tgt_valid, latch the target, set speaker=1, cnt=0 and go to PLAY; otherwise go to IDLE.
//    - enable_r==0 during GAP: go to IDLE immediately.
//  The target is sampled at the gap end, not at gap start.
//  playing, note_active and octave_active are registered and follow the state on the same edge.
//  No arithmetic overflow: cnt never exceeds cur_H-1; gcnt never exceeds GAP_CYCLES-1.
// TESTING (bench overrides GAP_CYCLES=16)
//  1. Reset, then note=6 oct=01 enable=1:
//     - speaker rises 2 cycles after the change.
//     - Then alternates 113636 high / 113636 low; playing=1; note_active=6.
//  2. Same note with oct=00, then oct=10:
//     - oct=00 gives half-period 227272.
//     - oct=10 gives half-period 56818.
//     - oct=11 or note=9 gives speaker=0 and playing=0.
//  3. Playing note=1 oct=01, change to note=5 mid-high-phase:
//     - high phase completes its full 191110 cycles.
//     - speaker then stays 0 for 16 cycles (GAP).
//     - Then 127551-cycle half-periods begin with speaker=1.
//  4. Playing note=3, re-apply note=3:
//     - no gap, no phase change.
//     - Then drop to note=0: speaker=0 from the next boundary, GAP, then IDLE.
//  5. Deassert enable mid-PLAY and again mid-GAP:
//     - speaker=0 and playing=0 two edges after the port change.
//     - State ends in IDLE.
//  6. Assert reset=0 mid-high-phase:
//     - all outputs are 0 after that edge.
//     - After release, the tone restarts with a full first half-period.

Source files
------------

// File: rtl/buzzer_if.sv
// buzzer_if: note bus from the mode controller into the buzzer driver, plus tone status back out
interface buzzer_if;
  logic       enable;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       speaker;
  logic       playing;
  logic [3:0] note_active;
  logic [1:0] octave_active;
  modport master (output enable, note_in, octave_in, input speaker, playing, note_active, octave_active);
  modport slave (input enable, note_in, octave_in, output speaker, playing, note_active, octave_active);
endinterface

// File: rtl/buzzer_driver.sv
// buzzer_driver: note/octave codes to a glitch-free 50%-duty square wave with silent gaps between notes
module buzzer_driver #(
  parameter int GAP_CYCLES = 1_000_000,
  parameter int CNT_W      = 19
) (
  input logic     clk,
  input logic     reset,
  buzzer_if.slave bus
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t           state, state_n;
  logic             en_r, spk, spk_n, playing, start;
  logic [3:0]       note_r, note_a, note_a_n;
  logic [1:0]       oct_r, oct_a, oct_a_n;
  logic [CNT_W-1:0] base_h, tgt_h, cur_h, cur_h_n, cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             tgt_valid, same_tgt, boundary, gap_end;
  always_comb begin
    base_h    = note_r == 4'd1 ? CNT_W'(191110) :
                note_r == 4'd2 ? CNT_W'(170266) :
                note_r == 4'd3 ? CNT_W'(151685) :
                note_r == 4'd4 ? CNT_W'(143172) :
                note_r == 4'd5 ? CNT_W'(127551) :
                note_r == 4'd6 ? CNT_W'(113636) :
                note_r == 4'd7 ? CNT_W'(101240) : '0;
    tgt_h     = oct_r == 2'b00 ? base_h << 1 : oct_r == 2'b10 ? base_h >> 1 : base_h;
    tgt_valid = note_r != 4'd0 && !note_r[3] && oct_r != 2'b11;
    same_tgt  = note_r == note_a && oct_r == oct_a;
    boundary  = cnt == cur_h - 1'b1;
    gap_end   = gcnt == GW'(GAP_CYCLES - 1);
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    cur_h_n  = cur_h;
    spk_n    = spk;
    note_a_n = note_a;
    oct_a_n  = oct_a;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        spk_n    = 1'b0;
        cnt_n    = '0;
        gcnt_n   = '0;
        note_a_n = '0;
        oct_a_n  = '0;
        start    = en_r && tgt_valid;
      end
      PLAY: begin
        if (!en_r) begin
          state_n  = IDLE;
          spk_n    = 1'b0;
          cnt_n    = '0;
          note_a_n = '0;
          oct_a_n  = '0;
        end else if (!boundary) begin
          cnt_n = cnt + 1'b1;
        end else if (tgt_valid && same_tgt) begin
          cnt_n = '0;
          spk_n = ~spk;
        end else begin
          state_n  = GAP;
          cnt_n    = '0;
          gcnt_n   = '0;
          spk_n    = 1'b0;
          note_a_n = '0;
          oct_a_n  = '0;
        end
      end
      GAP: begin
        spk_n = 1'b0;
        if (!en_r) begin
          state_n = IDLE;
          gcnt_n  = '0;
        end else if (!gap_end) begin
          gcnt_n = gcnt + 1'b1;
        end else begin
          state_n = IDLE;
          gcnt_n  = '0;
          start   = tgt_valid;
        end
      end
      default: state_n = IDLE;
    endcase
    // the target is latched only here, so a note never changes mid half-period
    if (start) begin
      state_n  = PLAY;
      cur_h_n  = tgt_h;
      note_a_n = note_r;
      oct_a_n  = oct_r;
      cnt_n    = '0;
      spk_n    = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state   <= IDLE;
      en_r    <= 1'b0;
      note_r  <= '0;
      oct_r   <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      cur_h   <= '0;
      spk     <= 1'b0;
      playing <= 1'b0;
      note_a  <= '0;
      oct_a   <= '0;
    end else begin
      state   <= state_n;
      en_r    <= bus.enable;
      note_r  <= bus.note_in;
      oct_r   <= bus.octave_in;
      cnt     <= cnt_n;
      gcnt    <= gcnt_n;
      cur_h   <= cur_h_n;
      spk     <= spk_n;
      playing <= state_n == PLAY;
      note_a  <= note_a_n;
      oct_a   <= oct_a_n;
    end
  assign bus.speaker       = spk;
  assign bus.playing       = playing;
  assign bus.note_active   = note_a;
  assign bus.octave_active = oct_a;
endmodule
